// File: rtl/tt_ctrl_pkg.sv
// Shared types for the user-design control sequencer: FSM state encoding and
// the decode from state to the wrapper's ENA/RST_N pair.
package tt_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_ENA_WAIT = 2'd1,
    ST_RUN      = 2'd2
  } state_e;

  localparam logic [1:0] ST_UNREACHABLE = 2'd3;

  // Returns {ena, rst_n} for the wrapper; ENA always leads RST_N.
  function automatic logic [1:0] ctrl_decode(input state_e st);
    logic [1:0] ctrl;
    case (st)
      ST_HOLD:     ctrl = 2'b00;
      ST_ENA_WAIT: ctrl = 2'b10;
      ST_RUN:      ctrl = 2'b11;
      default:     ctrl = 2'b00;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/tt_ctrl_sequencer_if.sv
// Pad-side inputs and wrapper-side outputs of the control sequencer.
// The slave modport is the sequencer; the master side drives the pads.
interface tt_ctrl_sequencer_if;

  logic [7:0] ui_pad_in;
  logic [7:0] uio_pad_in;
  logic       btn_rst_pad;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic       ena_out;
  logic       rst_n_out;
  logic [1:0] state_o;

  modport master (
    output ui_pad_in, uio_pad_in, btn_rst_pad,
    input  ui_in, uio_in, ena_out, rst_n_out, state_o
  );

  modport slave (
    input  ui_pad_in, uio_pad_in, btn_rst_pad,
    output ui_in, uio_in, ena_out, rst_n_out, state_o
  );

endinterface

// File: rtl/tt_ctrl_sequencer_chk.sv
// Invariants on the wrapper control outputs of the sequencer.
module tt_ctrl_sequencer_chk
  import tt_ctrl_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  input logic       ena_out,
  input logic       rst_n_out,
  input logic [1:0] state_o
);

  // The wrapper may only leave reset while it is enabled.
  a_rst_needs_ena: assert property (@(posedge clk) disable iff (!rst_n)
    rst_n_out |-> ena_out);

  a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
    state_o != ST_UNREACHABLE);

  a_ctrl_matches_state: assert property (@(posedge clk) disable iff (!rst_n)
    {ena_out, rst_n_out} == ctrl_decode(state_e'(state_o)));

endmodule

// File: rtl/tt_sync_ff.sv
// Multi-flop synchronizer: every bit is an independent STAGES-deep chain,
// so a pad change reaches q exactly STAGES clock edges later.
module tt_sync_ff #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [STAGES];

  // Shift the pad sample one stage per edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign q = stage_r[STAGES-1];

endmodule

// File: rtl/tt_ctrl_sequencer.sv
// Input synchronizers, reset-button debouncer and the ENA / RST_N release
// sequencer feeding the user-design wrapper.
module tt_ctrl_sequencer
  import tt_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES      = 2,
  parameter int RST_HOLD_CYCLES  = 16,
  parameter int ENA_DELAY_CYCLES = 4,
  parameter int DEBOUNCE_CYCLES  = 8
) (
  input logic                clk,
  input logic                rst_n,
  tt_ctrl_sequencer_if.slave bus
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES) + 1;
  localparam int DLY_W  = $clog2(ENA_DELAY_CYCLES) + 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(ENA_DELAY_CYCLES - 1);

  logic [7:0]        ui_sync_s;
  logic [7:0]        uio_sync_s;
  logic              btn_s;
  logic              btn_db_r;
  logic [DB_W-1:0]   db_cnt_r;
  state_e            state_r;
  state_e            state_nxt_s;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [HOLD_W-1:0] hold_cnt_nxt_s;
  logic [DLY_W-1:0]  dly_cnt_r;
  logic [DLY_W-1:0]  dly_cnt_nxt_s;
  logic              ena_r;
  logic              rst_n_out_r;

  tt_sync_ff #(.WIDTH(8), .STAGES(SYNC_STAGES)) u_ui_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.ui_pad_in),
    .q     (ui_sync_s)
  );

  tt_sync_ff #(.WIDTH(8), .STAGES(SYNC_STAGES)) u_uio_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.uio_pad_in),
    .q     (uio_sync_s)
  );

  tt_sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_btn_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.btn_rst_pad),
    .q     (btn_s)
  );

  // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_r <= '0;
      btn_db_r <= 1'b0;
    end else if (btn_s == btn_db_r) begin
      db_cnt_r <= '0;
    end else if (db_cnt_r == DB_LAST) begin
      db_cnt_r <= '0;
      btn_db_r <= ~btn_db_r;
    end else begin
      db_cnt_r <= db_cnt_r + 1'b1;
    end
  end

  // Next-state logic; a debounced press always wins over counter completion
  always_comb begin
    state_nxt_s    = state_r;
    hold_cnt_nxt_s = hold_cnt_r;
    dly_cnt_nxt_s  = dly_cnt_r;
    case (state_r)
      ST_HOLD: begin
        dly_cnt_nxt_s = '0;
        if (btn_db_r) begin
          hold_cnt_nxt_s = '0;
        end else if (hold_cnt_r == HOLD_LAST) begin
          hold_cnt_nxt_s = '0;
          state_nxt_s    = ST_ENA_WAIT;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r + 1'b1;
        end
      end
      ST_ENA_WAIT: begin
        hold_cnt_nxt_s = '0;
        if (btn_db_r) begin
          dly_cnt_nxt_s = '0;
          state_nxt_s   = ST_HOLD;
        end else if (dly_cnt_r == DLY_LAST) begin
          dly_cnt_nxt_s = '0;
          state_nxt_s   = ST_RUN;
        end else begin
          dly_cnt_nxt_s = dly_cnt_r + 1'b1;
        end
      end
      ST_RUN: begin
        hold_cnt_nxt_s = '0;
        dly_cnt_nxt_s  = '0;
        if (btn_db_r) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        hold_cnt_nxt_s = '0;
        dly_cnt_nxt_s  = '0;
        state_nxt_s    = ST_HOLD;
      end
    endcase
  end

  // Sequencer state and outputs, decoded from next-state so they move together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_HOLD;
      hold_cnt_r  <= '0;
      dly_cnt_r   <= '0;
      ena_r       <= 1'b0;
      rst_n_out_r <= 1'b0;
    end else begin
      state_r                <= state_nxt_s;
      hold_cnt_r             <= hold_cnt_nxt_s;
      dly_cnt_r              <= dly_cnt_nxt_s;
      {ena_r, rst_n_out_r}   <= ctrl_decode(state_nxt_s);
    end
  end

  assign bus.ui_in     = ui_sync_s;
  assign bus.uio_in    = uio_sync_s;
  assign bus.ena_out   = ena_r;
  assign bus.rst_n_out = rst_n_out_r;
  assign bus.state_o   = state_r;

  tt_ctrl_sequencer_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena_out   (ena_r),
    .rst_n_out (rst_n_out_r),
    .state_o   (state_r)
  );

endmodule

// File: tb/tb_tt_ctrl_sequencer.sv
// Directed bench for tt_ctrl_sequencer: expectations are queued with their due
// edge when stimulus is applied and checked when that edge has passed.
module tb_tt_ctrl_sequencer;

  localparam int S = 2;
  localparam int H = 16;
  localparam int E = 4;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst_n;

  tt_ctrl_sequencer_if bus();

  tt_ctrl_sequencer #(
    .SYNC_STAGES      (S),
    .RST_HOLD_CYCLES  (H),
    .ENA_DELAY_CYCLES (E),
    .DEBOUNCE_CYCLES  (D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // kind 0: {ui_in,uio_in} = {a,b}; kind 1: {ena,rst_n_out,state} = a[3:0]; kind 2: btn_db = a[0]
  typedef struct {
    int         due;
    int         kind;
    logic [7:0] a;
    logic [7:0] b;
    string      tag;
  } exp_t;

  exp_t       q[$];
  int         cyc   = 0;
  int         n_cmp = 0;
  int         n_mis = 0;
  logic [7:0] cur_ui  = 8'h00;
  logic [7:0] cur_uio = 8'h00;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int due, input int kind, input logic [7:0] a,
                      input logic [7:0] b, input string tag);
    exp_t e;
    int   i;
    e.due = due; e.kind = kind; e.a = a; e.b = b; e.tag = tag;
    i = q.size();
    while (i > 0 && q[i-1].due > due) i--;
    q.insert(i, e);
  endtask

  task automatic push_ctrl(input int due, input logic [1:0] st, input string tag);
    logic [7:0] v;
    v = {4'b0000, (st != 2'd0), (st == 2'd2), st};
    push(due, 1, v, 8'h00, tag);
  endtask

  task automatic check_due();
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      case (e.kind)
        0:       chk($sformatf("%s@%0d", e.tag, e.due), {bus.ui_in, bus.uio_in}, {e.a, e.b});
        1:       chk($sformatf("%s@%0d", e.tag, e.due),
                     {12'd0, bus.ena_out, bus.rst_n_out, bus.state_o}, {8'd0, e.a});
        default: chk($sformatf("%s@%0d", e.tag, e.due), {15'd0, dut.btn_db_r}, {8'd0, e.a});
      endcase
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_due();
    end
  endtask

  task automatic drive_data(input logic [7:0] a, input logic [7:0] b, input string tag);
    push(cyc + 1, 0, cur_ui, cur_uio, {tag, "_old"});
    push(cyc + S, 0, a, b, {tag, "_new"});
    bus.ui_pad_in  = a;
    bus.uio_pad_in = b;
    cur_ui  = a;
    cur_uio = b;
  endtask

  // Edge k after rst_n release: HOLD for H-1 edges, ENA_WAIT for E, then RUN
  function automatic logic [1:0] seq_state(input int k, input bit prio);
    if (k < H)          return 2'd0;
    else if (k < H + E) return 2'd1;
    else if (prio)      return 2'd0;
    else                return 2'd2;
  endfunction

  // Long button press seen from RUN: debounce in at +10, out at +40, then full re-sequence
  function automatic logic [1:0] press_state(input int k);
    if (k <= 10)      return 2'd2;
    else if (k <= 55) return 2'd0;
    else if (k <= 59) return 2'd1;
    else              return 2'd2;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_ui"},    {8'd0, bus.ui_in},      16'd0);
    chk({tag, "_uio"},   {8'd0, bus.uio_in},     16'd0);
    chk({tag, "_ena"},   {15'd0, bus.ena_out},   16'd0);
    chk({tag, "_rstn"},  {15'd0, bus.rst_n_out}, 16'd0);
    chk({tag, "_state"}, {14'd0, bus.state_o},   16'd0);
  endtask

  initial begin
    int base;
    int p;

    rst_n           = 1'b0;
    bus.ui_pad_in   = 8'hFF;
    bus.uio_pad_in  = 8'hFF;
    bus.btn_rst_pad = 1'b0;
    tick(3);
    check_all_zero("reset");
    chk("reset_btn_db", {15'd0, dut.btn_db_r}, 16'd0);

    // Power-on sequence with data changes in HOLD, ENA_WAIT and RUN
    bus.ui_pad_in  = 8'h00;
    bus.uio_pad_in = 8'h00;
    rst_n = 1'b1;
    base  = cyc;
    for (int k = 1; k <= 24; k++) push_ctrl(base + k, seq_state(k, 1'b0), "por_seq");
    push(base + 5, 0, 8'h00, 8'h00, "por_data_idle");
    tick(8);
    drive_data(8'hA5, 8'h3C, "data_hold");
    tick(8);
    drive_data(8'h5A, 8'hC3, "data_enawait");
    tick(6);
    drive_data(8'h0F, 8'hF0, "data_run");
    tick(4);

    // Three short bounces in RUN must not disturb anything
    for (int k = 1; k <= 35; k++) begin
      push_ctrl(cyc + k, 2'd2, "bounce_ctrl");
      push(cyc + k, 2, 8'h00, 8'h00, "bounce_db");
    end
    for (int r = 0; r < 3; r++) begin
      bus.btn_rst_pad = 1'b1;
      tick(5);
      bus.btn_rst_pad = 1'b0;
      tick(5);
    end
    tick(5);

    // Real press from RUN, held 30 cycles
    p = cyc;
    for (int k = 1; k <= 62; k++) push_ctrl(p + k, press_state(k), "press_seq");
    push(p + 9,  2, 8'h00, 8'h00, "press_db_pre");
    push(p + 10, 2, 8'h01, 8'h00, "press_db_rise");
    bus.btn_rst_pad = 1'b1;
    tick(30);
    push(p + 39, 2, 8'h01, 8'h00, "press_db_pre_fall");
    push(p + 40, 2, 8'h00, 8'h00, "press_db_fall");
    bus.btn_rst_pad = 1'b0;
    tick(32);

    // Asynchronous reset pulse mid-RUN, then the full sequence again
    drive_data(8'h77, 8'h88, "data_pre_arst");
    tick(3);
    #2 rst_n = 1'b0;
    #1 check_all_zero("arst");
    #1 rst_n = 1'b1;
    base = cyc;
    for (int k = 1; k <= 24; k++) push_ctrl(base + k, seq_state(k, 1'b0), "arst_seq");
    push(base + 1, 0, 8'h00, 8'h00, "arst_data_old");
    push(base + 2, 0, 8'h77, 8'h88, "arst_data_new");
    tick(26);

    // Debounced press lands exactly when ENA_WAIT would complete
    #2 rst_n = 1'b0;
    #1 check_all_zero("prio_rst");
    #1 rst_n = 1'b1;
    base = cyc;
    for (int k = 1; k <= 30; k++) push_ctrl(base + k, seq_state(k, 1'b1), "prio_seq");
    push(base + 18, 2, 8'h00, 8'h00, "prio_db_pre");
    push(base + 19, 2, 8'h01, 8'h00, "prio_db_rise");
    tick(9);
    bus.btn_rst_pad = 1'b1;
    tick(21);
    bus.btn_rst_pad = 1'b0;

    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
